// File: rtl/dcache_ctrl_if.sv
// CPU data port and off-chip block-memory port of the L1 data cache.
// The slave modport is the cache; the master modport is the CPU/memory side.
interface dcache_ctrl_if;
    logic         cpu_req_i;
    logic         cpu_we_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
        output cpu_data_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_data_o
    );

    modport master (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
        input  cpu_data_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_data_o
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache with 32-byte blocks.
// Hits complete with no added latency; misses stall the pipeline until refilled.
module dcache_ctrl #(
    parameter int INDEX_BITS  = 5,
    parameter int OFFSET_BITS = 5
) (
    input  logic          clk_i,
    input  logic          rst_i,
    dcache_ctrl_if.slave  bus
);

    localparam int TAG_BITS  = 32 - INDEX_BITS - OFFSET_BITS;
    localparam int NUM_LINES = 2 ** INDEX_BITS;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2
    } state_t;

    function automatic logic [31:0] word_get(input logic [255:0] blk, input logic [2:0] w);
        return blk[{w, 5'b00000} +: 32];
    endfunction

    function automatic logic [255:0] word_put(input logic [255:0] blk, input logic [2:0] w,
                                              input logic [31:0] val);
        logic [255:0] r;
        r = blk;
        r[{w, 5'b00000} +: 32] = val;
        return r;
    endfunction

    state_t                 state_r;
    logic [NUM_LINES-1:0]   valid_r;
    logic [NUM_LINES-1:0]   dirty_r;
    logic [TAG_BITS-1:0]    tag_arr_r  [NUM_LINES];
    logic [255:0]           data_arr_r [NUM_LINES];
    logic [TAG_BITS-1:0]    miss_tag_r;
    logic [INDEX_BITS-1:0]  miss_idx_r;
    logic                   mem_req_r;
    logic                   mem_we_r;
    logic [31:0]            mem_addr_r;
    logic [255:0]           mem_data_r;

    logic [TAG_BITS-1:0]    req_tag_s;
    logic [INDEX_BITS-1:0]  req_idx_s;
    logic [2:0]             req_word_s;
    logic                   hit_s;
    logic                   miss_s;
    logic [31:0]            victim_addr_s;
    logic [31:0]            fill_addr_s;
    logic [31:0]            alloc_addr_s;
    logic [31:0]            cpu_data_s;
    logic                   cpu_stall_s;
    logic                   arr_we_s;
    logic [INDEX_BITS-1:0]  arr_idx_s;
    logic [TAG_BITS-1:0]    arr_tag_s;
    logic [255:0]           arr_data_s;
    logic                   unused_addr_s;

    assign req_tag_s     = bus.cpu_addr_i[31 -: TAG_BITS];
    assign req_idx_s     = bus.cpu_addr_i[OFFSET_BITS +: INDEX_BITS];
    assign req_word_s    = bus.cpu_addr_i[4:2];
    assign unused_addr_s = ^bus.cpu_addr_i[1:0];

    assign hit_s  = bus.cpu_req_i & (state_r == ST_IDLE) & valid_r[req_idx_s] &
                    (tag_arr_r[req_idx_s] == req_tag_s);
    assign miss_s = bus.cpu_req_i & (state_r == ST_IDLE) & ~hit_s;

    assign victim_addr_s = {tag_arr_r[req_idx_s], req_idx_s, {OFFSET_BITS{1'b0}}};
    assign fill_addr_s   = {req_tag_s, req_idx_s, {OFFSET_BITS{1'b0}}};
    assign alloc_addr_s  = {miss_tag_r, miss_idx_r, {OFFSET_BITS{1'b0}}};

    // CPU-facing stall and load data; forced quiet while reset is held.
    always_comb begin
        cpu_data_s  = 32'h0000_0000;
        cpu_stall_s = 1'b0;
        if (rst_i) begin
            cpu_stall_s = 1'b0;
        end else if (state_r != ST_IDLE) begin
            cpu_stall_s = 1'b1;
        end else if (hit_s) begin
            if (!bus.cpu_we_i) begin
                cpu_data_s = word_get(data_arr_r[req_idx_s], req_word_s);
            end else begin
                cpu_data_s = 32'h0000_0000;
            end
        end else if (bus.cpu_req_i) begin
            cpu_stall_s = 1'b1;
        end else begin
            cpu_stall_s = 1'b0;
        end
    end

    // Line array write port: refill on the allocate ack, or a single-word store hit.
    always_comb begin
        arr_we_s   = 1'b0;
        arr_idx_s  = req_idx_s;
        arr_tag_s  = req_tag_s;
        arr_data_s = bus.mem_data_i;
        if ((state_r == ST_ALLOCATE) && bus.mem_ack_i) begin
            arr_we_s   = 1'b1;
            arr_idx_s  = miss_idx_r;
            arr_tag_s  = miss_tag_r;
            arr_data_s = bus.mem_data_i;
        end else if (hit_s && bus.cpu_we_i) begin
            arr_we_s   = 1'b1;
            arr_idx_s  = req_idx_s;
            arr_tag_s  = tag_arr_r[req_idx_s];
            arr_data_s = word_put(data_arr_r[req_idx_s], req_word_s, bus.cpu_data_i);
        end else begin
            arr_we_s   = 1'b0;
        end
    end

    // Tag and data storage carry no reset; valid bits gate their use.
    always_ff @(posedge clk_i) begin
        if (arr_we_s) begin
            tag_arr_r[arr_idx_s]  <= arr_tag_s;
            data_arr_r[arr_idx_s] <= arr_data_s;
        end
    end

    // Miss-handling FSM with registered memory-port outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= ST_IDLE;
            valid_r    <= {NUM_LINES{1'b0}};
            dirty_r    <= {NUM_LINES{1'b0}};
            miss_tag_r <= {TAG_BITS{1'b0}};
            miss_idx_r <= {INDEX_BITS{1'b0}};
            mem_req_r  <= 1'b0;
            mem_we_r   <= 1'b0;
            mem_addr_r <= 32'h0000_0000;
            mem_data_r <= {256{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (miss_s) begin
                        miss_tag_r <= req_tag_s;
                        miss_idx_r <= req_idx_s;
                        mem_req_r  <= 1'b1;
                        if (valid_r[req_idx_s] && dirty_r[req_idx_s]) begin
                            state_r    <= ST_WRITEBACK;
                            mem_we_r   <= 1'b1;
                            mem_addr_r <= victim_addr_s;
                            mem_data_r <= data_arr_r[req_idx_s];
                        end else begin
                            state_r    <= ST_ALLOCATE;
                            mem_we_r   <= 1'b0;
                            mem_addr_r <= fill_addr_s;
                            mem_data_r <= {256{1'b0}};
                        end
                    end else if (hit_s && bus.cpu_we_i) begin
                        dirty_r[req_idx_s] <= 1'b1;
                    end
                end
                ST_WRITEBACK: begin
                    // Request stays high; only direction and address switch to the refill.
                    if (bus.mem_ack_i) begin
                        dirty_r[miss_idx_r] <= 1'b0;
                        state_r    <= ST_ALLOCATE;
                        mem_we_r   <= 1'b0;
                        mem_addr_r <= alloc_addr_s;
                        mem_data_r <= {256{1'b0}};
                    end
                end
                ST_ALLOCATE: begin
                    if (bus.mem_ack_i) begin
                        valid_r[miss_idx_r] <= 1'b1;
                        dirty_r[miss_idx_r] <= 1'b0;
                        state_r    <= ST_IDLE;
                        mem_req_r  <= 1'b0;
                        mem_we_r   <= 1'b0;
                        mem_addr_r <= 32'h0000_0000;
                        mem_data_r <= {256{1'b0}};
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    mem_req_r  <= 1'b0;
                    mem_we_r   <= 1'b0;
                    mem_addr_r <= 32'h0000_0000;
                    mem_data_r <= {256{1'b0}};
                end
            endcase
        end
    end

    assign bus.cpu_data_o  = cpu_data_s;
    assign bus.cpu_stall_o = cpu_stall_s;
    assign bus.mem_req_o   = mem_req_r;
    assign bus.mem_we_o    = mem_we_r;
    assign bus.mem_addr_o  = mem_addr_r;
    assign bus.mem_data_o  = mem_data_r;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a cache/memory model predicts hit/miss,
// writeback and refill traffic and load data, checked on every cycle of each access.
module tb_dcache_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    dcache_ctrl_if bus();

    dcache_ctrl dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: what the cache should hold and what memory should hold.
    bit           m_valid [32];
    bit           m_dirty [32];
    logic [21:0]  m_tag   [32];
    logic [255:0] m_line  [32];
    logic [255:0] mem_model [int];

    int           stall_cnt;
    logic [31:0]  last_data;
    logic [31:0]  seen_wb_addr;
    logic [31:0]  seen_wb_word1;
    logic [31:0]  seen_al_addr;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] mem_rd(input int blk);
        logic [255:0] r;
        if (mem_model.exists(blk)) return mem_model[blk];
        for (int w = 0; w < 8; w++)
            r[w*32 +: 32] = 32'h5A00_0000 ^ (32'(blk) << 3) ^ 32'(w);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        bus.cpu_req_i = 1'b0;
        bus.cpu_we_i  = 1'b0;
        bus.mem_ack_i = 1'b0;
        #1;
        chk("idle_stall", {255'd0, bus.cpu_stall_o}, 256'd0);
        chk("idle_data", {224'd0, bus.cpu_data_o}, 256'd0);
        chk("idle_mem_req", {255'd0, bus.mem_req_o}, 256'd0);
    endtask

    // One CPU access with memory latencies wl (writeback) and al (refill) in cycles.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input int wl, input int al);
        logic [4:0]   idx;
        logic [21:0]  tg;
        logic [2:0]   w;
        bit           hit;
        bit           dvict;
        logic [31:0]  vaddr;
        logic [31:0]  aaddr;
        logic [255:0] vblk;
        logic [255:0] fblk;
        logic [255:0] final_line;
        int           nwb;
        int           nal;
        int           total;
        logic         e_stall;
        logic         e_req;
        logic         e_we;
        logic [31:0]  e_addr;
        logic [255:0] e_mdata;

        idx   = addr[9:5];
        tg    = addr[31:10];
        w     = addr[4:2];
        hit   = m_valid[idx] && (m_tag[idx] == tg);
        dvict = !hit && m_valid[idx] && m_dirty[idx];
        vaddr = {m_tag[idx], idx, 5'b00000};
        vblk  = m_line[idx];
        aaddr = {tg, idx, 5'b00000};
        fblk  = mem_rd(int'(aaddr >> 5));
        nwb   = dvict ? wl : 0;
        nal   = hit ? 0 : al;
        total = hit ? 1 : (2 + nwb + nal);
        final_line = hit ? m_line[idx] : fblk;
        stall_cnt  = 0;

        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            bus.cpu_req_i  = 1'b1;
            bus.cpu_we_i   = we;
            bus.cpu_addr_i = addr;
            bus.cpu_data_i = wd;
            bus.mem_ack_i  = 1'b0;
            bus.mem_data_i = {256{1'b0}};
            e_stall = 1'b1;
            e_req   = 1'b0;
            e_we    = 1'b0;
            e_addr  = 32'h0;
            e_mdata = {256{1'b0}};
            if (c == total - 1) begin
                e_stall = 1'b0;
            end else if (c >= 1 && c <= nwb) begin
                e_req   = 1'b1;
                e_we    = 1'b1;
                e_addr  = vaddr;
                e_mdata = vblk;
                bus.mem_ack_i = (c == nwb);
            end else if (c > nwb && c <= nwb + nal) begin
                e_req  = 1'b1;
                e_addr = aaddr;
                if (c == nwb + nal) begin
                    bus.mem_ack_i  = 1'b1;
                    bus.mem_data_i = fblk;
                end
            end
            #1;
            chk("stall", {255'd0, bus.cpu_stall_o}, {255'd0, e_stall});
            chk("mem_req", {255'd0, bus.mem_req_o}, {255'd0, e_req});
            chk("mem_we", {255'd0, bus.mem_we_o}, {255'd0, e_we});
            chk("mem_addr", {224'd0, bus.mem_addr_o}, {224'd0, e_addr});
            chk("mem_data", bus.mem_data_o, e_mdata);
            if (bus.cpu_stall_o) stall_cnt++;
            if (e_we) begin
                seen_wb_addr  = bus.mem_addr_o;
                seen_wb_word1 = bus.mem_data_o[63:32];
            end
            if (e_req && !e_we) seen_al_addr = bus.mem_addr_o;
            if (c == total - 1 && !we) begin
                chk("load_data", {224'd0, bus.cpu_data_o}, {224'd0, final_line[w*32 +: 32]});
                last_data = bus.cpu_data_o;
            end
        end
        @(negedge clk);
        bus.mem_ack_i = 1'b0;
        bus.cpu_req_i = 1'b0;

        if (dvict) mem_model[int'(vaddr >> 5)] = vblk;
        if (!hit) begin
            m_line[idx]  = fblk;
            m_tag[idx]   = tg;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
        end
        if (we) begin
            m_line[idx][w*32 +: 32] = wd;
            m_dirty[idx] = 1'b1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] blk;
        checks = 0;
        errors = 0;
        model_reset();

        // Reset held while the CPU presents traffic: everything quiet without a clock edge.
        rst            = 1'b1;
        bus.cpu_req_i  = 1'b1;
        bus.cpu_we_i   = 1'b0;
        bus.cpu_addr_i = 32'h0000_0404;
        bus.cpu_data_i = 32'h0;
        bus.mem_ack_i  = 1'b0;
        bus.mem_data_i = {256{1'b0}};
        #1;
        chk("rst_stall", {255'd0, bus.cpu_stall_o}, 256'd0);
        chk("rst_mem_req", {255'd0, bus.mem_req_o}, 256'd0);
        chk("rst_mem_addr", {224'd0, bus.mem_addr_o}, 256'd0);
        chk("rst_cpu_data", {224'd0, bus.cpu_data_o}, 256'd0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_hold_stall", {255'd0, bus.cpu_stall_o}, 256'd0);
        @(negedge clk);
        bus.cpu_req_i = 1'b0;
        rst = 1'b0;

        // Cold load, refill acked on the 10th allocate cycle.
        blk = mem_rd(32'h0000_0400 >> 5);
        blk[63:32] = 32'hDEAD_BEEF;
        mem_model[32'h0000_0400 >> 5] = blk;
        access(1'b0, 32'h0000_0404, 32'h0, 0, 10);
        chk("cold_stall_cycles", 256'(stall_cnt), 256'd11);
        chk("cold_data", {224'd0, last_data}, {224'd0, 32'hDEAD_BEEF});
        chk("cold_alloc_addr", {224'd0, seen_al_addr}, {224'd0, 32'h0000_0400});

        access(1'b0, 32'h0000_0408, 32'h0, 0, 1);
        chk("hit_stall_cycles", 256'(stall_cnt), 256'd0);
        idle_cycle();

        // Store hit then conflicting load forces a writeback of the dirtied block.
        access(1'b1, 32'h0000_0404, 32'h1234_5678, 0, 1);
        chk("store_hit_stall", 256'(stall_cnt), 256'd0);
        access(1'b0, 32'h0000_0804, 32'h0, 3, 4);
        chk("dirty_stall_cycles", 256'(stall_cnt), 256'd8);
        chk("wb_addr", {224'd0, seen_wb_addr}, {224'd0, 32'h0000_0400});
        chk("wb_word1", {224'd0, seen_wb_word1}, {224'd0, 32'h1234_5678});
        chk("dirty_alloc_addr", {224'd0, seen_al_addr}, {224'd0, 32'h0000_0800});
        access(1'b0, 32'h0000_0404, 32'h0, 1, 2);
        chk("wb_back_data", {224'd0, last_data}, {224'd0, 32'h1234_5678});

        // Store miss to a clean line: allocate only, store lands on replay.
        access(1'b1, 32'h0000_1048, 32'hCAFE_F00D, 5, 2);
        chk("store_miss_stall", 256'(stall_cnt), 256'd3);
        access(1'b0, 32'h0000_1048, 32'h0, 1, 1);
        chk("store_miss_data", {224'd0, last_data}, {224'd0, 32'hCAFE_F00D});
        access(1'b0, 32'h0000_2040, 32'h0, 1, 1);
        chk("conflict_stall", 256'(stall_cnt), 256'd3);
        chk("conflict_wb_addr", {224'd0, seen_wb_addr}, {224'd0, 32'h0000_1040});

        // Top word of the highest index, low address bits ignored.
        access(1'b1, 32'hFFFF_FFFF, 32'hA5A5_5A5A, 2, 3);
        access(1'b0, 32'hFFFF_FFFC, 32'h0, 1, 1);
        chk("top_word", {224'd0, last_data}, {224'd0, 32'hA5A5_5A5A});
        access(1'b0, 32'h0000_0C00, 32'h0, 1, 1);
        idle_cycle();

        // Reset during allocate: memory port drops at once, late ack ignored.
        @(negedge clk);
        bus.cpu_req_i  = 1'b1;
        bus.cpu_we_i   = 1'b0;
        bus.cpu_addr_i = 32'h0000_3000;
        #1;
        chk("mid_miss_stall", {255'd0, bus.cpu_stall_o}, 256'd1);
        @(negedge clk);
        #1;
        chk("mid_alloc_req", {255'd0, bus.mem_req_o}, 256'd1);
        chk("mid_alloc_addr", {224'd0, bus.mem_addr_o}, {224'd0, 32'h0000_3000});
        rst = 1'b1;
        #1;
        chk("mid_rst_req", {255'd0, bus.mem_req_o}, 256'd0);
        chk("mid_rst_addr", {224'd0, bus.mem_addr_o}, 256'd0);
        chk("mid_rst_stall", {255'd0, bus.cpu_stall_o}, 256'd0);
        repeat (2) @(negedge clk);
        @(negedge clk);
        rst            = 1'b0;
        bus.cpu_req_i  = 1'b0;
        bus.mem_ack_i  = 1'b1;
        bus.mem_data_i = {256{1'b1}};
        #1;
        chk("late_ack_req", {255'd0, bus.mem_req_o}, 256'd0);
        @(negedge clk);
        bus.mem_ack_i  = 1'b0;
        #1;
        chk("late_ack_stall", {255'd0, bus.cpu_stall_o}, 256'd0);
        chk("late_ack_req2", {255'd0, bus.mem_req_o}, 256'd0);
        model_reset();

        access(1'b0, 32'h0000_3000, 32'h0, 1, 2);
        chk("post_rst_miss", 256'(stall_cnt), 256'd3);
        access(1'b0, 32'h0000_0408, 32'h0, 1, 1);
        chk("post_rst_miss2", 256'(stall_cnt), 256'd2);
        idle_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Direct-mapped, write-back, write-allocate L1 data cache that sits directly downstream of the pipeline's MEM stage, between the CPU data port and a slow off-chip data memory. It serves hits with zero added latency. On a miss it raises a stall that freezes the whole pipeline (drives the CPU's all-stage stall), writes back a dirty victim if present, refills the 256-bit block, and then replays the access as a hit.

Parameters:
INDEX_BITS, 5, line index width; NUM_LINES = 2**INDEX_BITS (default 32)
OFFSET_BITS, 5, byte offset within a 32-byte (256-bit) block; fixed, not to be overridden
TAG_BITS, 32-INDEX_BITS-OFFSET_BITS (22), tag width; derived

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
cpu_req_i  in  1  MEM-stage access valid (load or store)
cpu_we_i  in  1  1 = store, 0 = load
cpu_addr_i  in  32  byte address; word-aligned
cpu_data_i  in  32  store data
cpu_data_o  out  32  load data; combinational on hit
cpu_stall_o  out  1  1 = freeze pipeline; combinational
mem_req_o  out  1  memory transaction request, level
mem_we_o  out  1  1 = block write (writeback), 0 = block read (refill)
mem_addr_o  out  32  block-aligned address, [4:0] = 0
mem_data_o  out  256  writeback block
mem_data_i  in  256  refill block; valid when mem_ack_i = 1
mem_ack_i  in  1  one-cycle pulse completing the current transaction

Behaviour:
- Address split: tag = addr[31:10], index = addr[9:5], word = addr[4:2]; addr[1:0] ignored. Word w occupies block bits [32w+31:32w].
- Internal state per line: valid, dirty, tag, 256-bit data. Reset clears every valid and dirty bit; tag and data contents are don't-care.
- FSM states: IDLE, WRITEBACK, ALLOCATE. Reset enters IDLE.
- Reset values: mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_data_o=0, cpu_data_o=0, cpu_stall_o=0.
- hit = cpu_req_i & valid[index] & (tag[index] == addr tag), evaluated in IDLE only.
- IDLE, no request: cpu_stall_o=0, cpu_data_o=0.
- IDLE, hit, load: cpu_data_o = selected word in the same cycle; cpu_stall_o=0.
- IDLE, hit, store: at the clock edge, write the selected word with cpu_data_i and set dirty=1; other words are unchanged; cpu_stall_o=0.
- IDLE, miss: cpu_stall_o=1 in the same cycle. Next state is WRITEBACK if valid & dirty, otherwise ALLOCATE.
- WRITEBACK: mem_req_o=1, mem_we_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_data_o = victim block, all held stable. On an edge with mem_ack_i=1: clear dirty and go to ALLOCATE.
- ALLOCATE: mem_req_o=1, mem_we_o=0, mem_addr_o={cpu tag, index, 5'b0}. On an edge with mem_ack_i=1: data = mem_data_i, tag = cpu tag, valid=1, dirty=0, then go to IDLE. The replay in IDLE is a hit (a store then writes and sets dirty).
- cpu_stall_o=1 throughout WRITEBACK and ALLOCATE. It drops in the first IDLE cycle after the refill, and the load data is valid in that cycle.
- Stall cycles: clean miss = 1 + A; dirty miss = 1 + W + A, where W and A are the cycles spent in WRITEBACK and ALLOCATE (each ≥ 1, including the ack cycle).
- mem_req_o stays high across the WRITEBACK→ALLOCATE transition, and the ack-edge changes mem_we_o/mem_addr_o. Memory must complete exactly one transaction per ack and must ignore mem_ack_i while mem_req_o=0.
- The CPU holds cpu_req_i, cpu_we_i, cpu_addr_i and cpu_data_i stable while stalled. If cpu_req_i drops mid-miss, the FSM still completes the refill; there is no abort.
- Outside WRITEBACK, mem_data_o=0 and mem_we_o=0. Outside WRITEBACK and ALLOCATE, mem_req_o=0 and mem_addr_o=0.
- Reset mid-operation: the FSM goes to IDLE and all mem_* outputs go to 0 immediately (asynchronously). All lines are invalidated, and loss of dirty data is accepted.

Test Plan:
- Reset hold during traffic → mem_req_o=0 and cpu_stall_o=0 with no clock edge; first access after release to any address misses.
- Cold load 0x0000_0404 with memory ack 10 cycles after req; refill block word1 = 0xDEAD_BEEF → stall for exactly 11 cycles, mem_addr_o=0x0000_0400, mem_we_o=0, cpu_data_o=0xDEAD_BEEF when stall drops.
- Load 0x0000_0408 immediately after → 0 stall, data = refill word2.
- Store 0x1234_5678 to 0x0000_0404 (hit) → no stall. Then load 0x0000_0804 (same index, different tag) → WRITEBACK to 0x0000_0400 with mem_data_o[63:32]=0x1234_5678, then ALLOCATE 0x0000_0800; stall = 1+W+A.
- Store miss to a clean line → ALLOCATE only (no WRITEBACK). After refill the stored word is updated, dirty=1, and a later conflict triggers writeback.
- Assert rst_i during ALLOCATE, before the ack → mem_req_o drops at once; a later ack is ignored; re-access misses again.
